// File: rtl/scpu_sequencer.sv
// scpu_sequencer: multi-cycle fetch/decode/exec control with PC, run/halt and fetch-timeout fault.
// Optional single-step mode via `SCPU_SINGLE_STEP_EN`.
module scpu_sequencer #(
    parameter int unsigned FETCH_TIMEOUT = 15
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       run,
`ifdef SCPU_SINGLE_STEP_EN
    input  logic       step,
`endif
    output logic       imem_req,
    output logic [3:0] imem_addr,
    input  logic       imem_ack,
    input  logic [7:0] imem_data,
    input  logic       equal,
    output logic       add,
    output logic       li,
    output logic       reg_we,
    output logic [3:0] imm,
    output logic [3:0] pc,
    output logic       halted,
    output logic       fault
);
    typedef enum logic [2:0] {IDLE, FETCH, DECODE, EXEC, HALT} state_t;

    localparam logic [3:0] OP_ADD  = 4'h1;
    localparam logic [3:0] OP_LI   = 4'h2;
    localparam logic [3:0] OP_HALT = 4'hF;
    localparam logic [7:0] TIMEOUT = FETCH_TIMEOUT[7:0];

    state_t     state_q, state_d;
    logic [3:0] pc_q, pc_d;
    logic [7:0] ir_q, ir_d;
    logic [7:0] cnt_q, cnt_d;
    logic       fault_q, fault_d;
    logic       add_q, add_d;
    logic       li_q, li_d;
    logic       start;
    state_t     exec_next;

    wire [3:0] op      = ir_q[7:4];
    wire [7:0] cnt_inc = cnt_q + 8'd1;

`ifdef SCPU_SINGLE_STEP_EN
    logic step_q;
    always_ff @(posedge clk or posedge rst)
        if (rst) step_q <= 1'b0;
        else     step_q <= step;
    // Edges seen outside IDLE are consumed by step_q and never reach the FSM.
    assign start     = run & step & ~step_q;
    assign exec_next = IDLE;
`else
    assign start     = run;
    assign exec_next = run ? FETCH : IDLE;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            pc_q    <= '0;
            ir_q    <= '0;
            cnt_q   <= '0;
            fault_q <= 1'b0;
            add_q   <= 1'b0;
            li_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            ir_q    <= ir_d;
            cnt_q   <= cnt_d;
            fault_q <= fault_d;
            add_q   <= add_d;
            li_q    <= li_d;
        end
    end

    // Counter is zero outside FETCH, so it starts clean on every entry.
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        ir_d    = ir_q;
        cnt_d   = '0;
        fault_d = fault_q;
        add_d   = 1'b0;
        li_d    = 1'b0;
        case (state_q)
            IDLE:    state_d = start ? FETCH : IDLE;
            FETCH: begin
                if (imem_ack) begin
                    ir_d    = imem_data;
                    state_d = DECODE;
                end else if (cnt_inc == TIMEOUT) begin
                    fault_d = 1'b1;
                    state_d = HALT;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            DECODE: begin
                state_d = (op == OP_HALT) ? HALT : EXEC;
                add_d   = (op == OP_ADD);
                li_d    = (op == OP_LI);
            end
            EXEC: begin
                pc_d    = ((add_q | li_q) & equal) ? ir_q[3:0] : pc_q + 4'd1;
                state_d = exec_next;
            end
            HALT:    state_d = HALT;
            default: state_d = IDLE;
        endcase
    end

    assign imem_req  = (state_q == FETCH);
    assign imem_addr = pc_q;
    assign add       = add_q;
    assign li        = li_q;
    assign reg_we    = add_q | li_q;
    assign imm       = ir_q[3:0];
    assign pc        = pc_q;
    assign halted    = (state_q == HALT);
    assign fault     = fault_q;
endmodule
